// File: rtl/xillybus_rd_stream_src.sv
// ============================================================================
// Module   : xillybus_rd_stream_src
// Function : User-side FIFO source for a Xillybus read stream, frames by count
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xillybus_rd_stream_src #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 9,
  parameter int LEN_W      = 16
) (
  input  logic              bus_clk,
  input  logic              bus_rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              smp_valid,
  input  logic [DATA_W-1:0] smp_data,
  output logic              smp_ready,
  input  logic              user_r_rden,
  output logic [DATA_W-1:0] user_r_data,
  output logic              user_r_empty,
  output logic              user_r_eof,
  input  logic              user_r_open,
  output logic              busy,
  output logic              overflow
);

  localparam int C_DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] C_FULL_CNT = (DEPTH_LOG2+1)'(C_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_EOF    = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_mem [C_DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0] r_count;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_wcnt;
  logic [DATA_W-1:0]   r_data;
  logic                r_eof;
  logic                r_ovf;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_start_ok;

  assign w_full     = (r_count == C_FULL_CNT);
  assign w_empty    = (r_count == '0);
  assign smp_ready  = (r_state == S_STREAM) && !w_full;
  assign w_push     = smp_valid && smp_ready;
  assign w_pop      = user_r_rden && !w_empty;
  assign w_start_ok = (r_state == S_IDLE) && start && user_r_open;

  assign user_r_data  = r_data;
  assign user_r_empty = w_empty;
  assign user_r_eof   = r_eof;
  assign busy         = (r_state != S_IDLE);
  assign overflow     = r_ovf;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_state_nxt = (frame_len == '0) ? S_EOF : S_STREAM;
        end
      end
      S_STREAM: begin
        if (w_push && (r_wcnt == r_len - LEN_W'(1))) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_empty && !w_push && !w_pop) begin
          w_state_nxt = S_EOF;
        end
      end
      S_EOF:   w_state_nxt = S_EOF;
      default: w_state_nxt = S_IDLE;
    endcase
    // Closing the device file wins over everything, including a start.
    if (!user_r_open) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge bus_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= smp_data;
    end
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (!user_r_open) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + DEPTH_LOG2'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + DEPTH_LOG2'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (DEPTH_LOG2+1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_LOG2+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge bus_clk or negedge bus_rst_n) begin
    if (!bus_rst_n) begin
      r_len  <= '0;
      r_wcnt <= '0;
      r_data <= '0;
      r_eof  <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_len  <= frame_len;
        r_wcnt <= '0;
      end else if (w_push) begin
        r_wcnt <= r_wcnt + LEN_W'(1);
      end
      if (w_pop) begin
        r_data <= r_mem[r_rptr];
      end
      r_eof <= user_r_open && (r_state == S_EOF);
      if (w_start_ok) begin
        r_ovf <= 1'b0;
      end else if ((r_state == S_STREAM) && smp_valid && w_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_xillybus_rd_stream_src.sv
// ============================================================================
// Module   : tb_xillybus_rd_stream_src
// Function : Directed bench with a queue-based frame model checked every cycle
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xillybus_rd_stream_src;

  logic        bus_clk;
  logic        bus_rst_n;
  logic        start;
  logic [15:0] frame_len;
  logic        smp_valid;
  logic [15:0] smp_data;
  logic        smp_ready;
  logic        user_r_rden;
  logic [15:0] user_r_data;
  logic        user_r_empty;
  logic        user_r_eof;
  logic        user_r_open;
  logic        busy;
  logic        overflow;

  xillybus_rd_stream_src #(.DATA_W(16), .DEPTH_LOG2(9), .LEN_W(16)) dut (
    .bus_clk     (bus_clk),
    .bus_rst_n   (bus_rst_n),
    .start       (start),
    .frame_len   (frame_len),
    .smp_valid   (smp_valid),
    .smp_data    (smp_data),
    .smp_ready   (smp_ready),
    .user_r_rden (user_r_rden),
    .user_r_data (user_r_data),
    .user_r_empty(user_r_empty),
    .user_r_eof  (user_r_eof),
    .user_r_open (user_r_open),
    .busy        (busy),
    .overflow    (overflow)
  );

  initial bus_clk = 1'b0;
  always #5 bus_clk = ~bus_clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Frame model: FIFO as a queue, frame progress as words still to accept.
  logic [15:0] m_q[$];
  int          m_rem;
  bit          m_active, m_ineof, m_eof, m_ovf;
  logic [15:0] m_data;

  function automatic bit m_ready();
    return m_active && !m_ineof && (m_rem > 0) && (m_q.size() < 512);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_rem = 0; m_active = 0; m_ineof = 0; m_eof = 0; m_ovf = 0; m_data = '0;
  endtask

  task automatic model_update();
    bit push, pop, ovf_set, drain_done, ineof_pre;
    int sz;
    sz         = m_q.size();
    push       = smp_valid && m_ready();
    pop        = user_r_rden && (sz > 0);
    ovf_set    = m_active && !m_ineof && (m_rem > 0) && smp_valid && (sz == 512);
    drain_done = m_active && !m_ineof && (m_rem == 0) && (sz == 0) && !pop;
    ineof_pre  = m_ineof;
    if (pop) m_data = m_q[0];
    if (ovf_set) m_ovf = 1;
    if (!user_r_open) begin
      m_q.delete(); m_active = 0; m_ineof = 0; m_eof = 0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) begin m_q.push_back(smp_data); m_rem--; end
      m_eof = ineof_pre;
      if (!m_active && start) begin
        m_active = 1; m_ovf = 0; m_rem = int'(frame_len); m_ineof = (frame_len == 16'd0);
      end else if (drain_done) begin
        m_ineof = 1;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge bus_clk);
      if (chk_en) begin
        chk("data",     32'(user_r_data),  32'(m_data));
        chk("empty",    32'(user_r_empty), 32'(m_q.size() == 0));
        chk("eof",      32'(user_r_eof),   32'(m_eof));
        chk("ready",    32'(smp_ready),    32'(m_ready()));
        chk("busy",     32'(busy),         32'(m_active));
        chk("overflow", 32'(overflow),     32'(m_ovf));
      end
    end
  end

  // Producer / reader drivers.
  bit          prod_on = 0, reader_on = 0, force_rd = 0;
  int          prod_idx = 0, prod_total = 0, prod_mode = 0;
  int          rd_cnt = 0, rd_limit = 1 << 30;
  logic [15:0] rx[$];

  function automatic logic [15:0] gen(input int i);
    if (prod_mode == 0) return 16'((i + 1) * 17);
    return 16'(32'h1000 + i);
  endfunction

  task automatic step();
    bit acc, rd;
    acc = smp_valid && smp_ready;
    rd  = user_r_rden && !user_r_empty;
    @(posedge bus_clk);
    if (!bus_rst_n) model_reset(); else model_update();
    #2;
    if (acc) prod_idx++;
    if (rd) begin rx.push_back(user_r_data); rd_cnt++; end
    smp_valid   = prod_on && (prod_idx < prod_total);
    smp_data    = gen(prod_idx);
    user_r_rden = force_rd || (reader_on && !user_r_empty && (rd_cnt < rd_limit));
  endtask

  task automatic begin_frame(input int len, input int total, input int mode);
    prod_idx = 0; prod_total = total; prod_mode = mode; rx.delete(); rd_cnt = 0;
    start = 1; frame_len = 16'(len);
    step();
    start = 0;
  endtask

  task automatic timeout(input string name);
    n_chk++;
    $display("FAIL %s: got timeout expected completion at %0t", name, $time);
  endtask

  initial begin
    bus_rst_n = 0; start = 0; frame_len = '0; smp_valid = 0; smp_data = '0;
    user_r_rden = 0; user_r_open = 0;
    model_reset();
    #12;
    chk("rst_empty", 32'(user_r_empty), 32'd1);
    chk("rst_eof",   32'(user_r_eof),   32'd0);
    chk("rst_data",  32'(user_r_data),  32'd0);
    chk("rst_ready", 32'(smp_ready),    32'd0);
    chk("rst_busy",  32'(busy),         32'd0);
    chk("rst_ovf",   32'(overflow),     32'd0);
    @(posedge bus_clk); #2;
    bus_rst_n = 1; chk_en = 1;

    // Basic 4-word frame, with a start during the frame that must be ignored.
    user_r_open = 1; step();
    prod_on = 1; reader_on = 1;
    begin_frame(4, 4, 0);
    step(); step();
    start = 1; frame_len = 16'd9; step(); start = 0;
    repeat (16) step();
    chk("basic_cnt", 32'(rx.size()), 32'd4);
    if (rx.size() == 4) begin
      chk("basic_w0", 32'(rx[0]), 32'h0011);
      chk("basic_w1", 32'(rx[1]), 32'h0022);
      chk("basic_w2", 32'(rx[2]), 32'h0033);
      chk("basic_w3", 32'(rx[3]), 32'h0044);
    end
    chk("basic_eof", 32'(user_r_eof), 32'd1);
    chk("basic_ovf", 32'(overflow),   32'd0);
    user_r_open = 0; step();
    chk("close_eof",  32'(user_r_eof), 32'd0);
    chk("close_busy", 32'(busy),       32'd0);

    // Zero-length frame.
    user_r_open = 1; step();
    begin_frame(0, 0, 0);
    chk("zl_busy",  32'(busy),         32'd1);
    chk("zl_eof0",  32'(user_r_eof),   32'd0);
    chk("zl_empty", 32'(user_r_empty), 32'd1);
    step();
    chk("zl_eof1",  32'(user_r_eof),   32'd1);
    chk("zl_ready", 32'(smp_ready),    32'd0);
    user_r_open = 0; step();

    // Full FIFO with backpressure, then drain all 600 words.
    user_r_open = 1; step();
    reader_on = 0; prod_on = 1;
    begin_frame(600, 600, 1);
    repeat (520) step();
    chk("full_acc",   32'(prod_idx),  32'd512);
    chk("full_ready", 32'(smp_ready), 32'd0);
    chk("full_ovf",   32'(overflow),  32'd1);
    reader_on = 1;
    for (int i = 0; i < 1000 && !(rx.size() == 600 && user_r_eof); i++) step();
    if (!(rx.size() == 600 && user_r_eof)) timeout("full_drain");
    chk("full_cnt", 32'(rx.size()), 32'd600);
    for (int i = 0; i < rx.size() && i < 600; i++) chk("full_word", 32'(rx[i]), 32'h1000 + 32'(i));
    chk("full_eof", 32'(user_r_eof), 32'd1);
    user_r_open = 0; step();

    // Read while empty, then simultaneous push and pop at a count of three.
    user_r_open = 1; reader_on = 0; prod_on = 0; step();
    begin_frame(10, 0, 0);
    step(); step();
    force_rd = 1; user_r_rden = 1;
    step(); step();
    force_rd = 0; step();
    chk("rde_data",  32'(user_r_data),  32'h1257);
    chk("rde_empty", 32'(user_r_empty), 32'd1);
    prod_total = 3; prod_on = 1; smp_valid = 1; smp_data = gen(0);
    for (int i = 0; i < 10 && prod_idx < 3; i++) step();
    if (prod_idx < 3) timeout("pp_fill");
    smp_valid = 1; smp_data = gen(3); user_r_rden = 1; prod_total = 4;
    step();
    reader_on = 1;
    repeat (8) step();
    chk("pp_cnt", 32'(rx.size()), 32'd4);
    if (rx.size() == 4) begin
      chk("pp_w0", 32'(rx[0]), 32'h0011);
      chk("pp_w3", 32'(rx[3]), 32'h0044);
    end
    chk("pp_busy", 32'(busy), 32'd1);
    user_r_open = 0; step();

    // Close mid-frame after 30 pushes and 10 reads; start alongside close.
    user_r_open = 1; reader_on = 0; step();
    prod_on = 1;
    begin_frame(100, 30, 0);
    for (int i = 0; i < 60 && prod_idx < 30; i++) step();
    if (prod_idx < 30) timeout("close_fill");
    rd_limit = 10; reader_on = 1;
    for (int i = 0; i < 30 && rx.size() < 10; i++) step();
    if (rx.size() < 10) timeout("close_reads");
    reader_on = 0;
    chk("mid_rx9",  32'(rx[9]),        32'h00aa);
    chk("mid_full", 32'(user_r_empty), 32'd0);
    user_r_open = 0; start = 1; frame_len = 16'd5;
    step();
    start = 0;
    chk("mid_busy",  32'(busy),         32'd0);
    chk("mid_empty", 32'(user_r_empty), 32'd1);
    chk("mid_eof",   32'(user_r_eof),   32'd0);
    step();
    chk("mid_busy2", 32'(busy), 32'd0);
    rd_limit = 1 << 30;

    // Asynchronous reset while draining.
    user_r_open = 1; step();
    prod_on = 1;
    begin_frame(5, 5, 0);
    for (int i = 0; i < 20 && prod_idx < 5; i++) step();
    if (prod_idx < 5) timeout("drain_fill");
    step();
    chk("drn_busy",  32'(busy),         32'd1);
    chk("drn_empty", 32'(user_r_empty), 32'd0);
    #1;
    bus_rst_n = 0; model_reset();
    #1;
    chk("arst_empty", 32'(user_r_empty), 32'd1);
    chk("arst_eof",   32'(user_r_eof),   32'd0);
    chk("arst_data",  32'(user_r_data),  32'd0);
    chk("arst_ovf",   32'(overflow),     32'd0);
    chk("arst_busy",  32'(busy),         32'd0);
    @(posedge bus_clk); #2;
    bus_rst_n = 1;
    step(); step();

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/xillybus_rd_stream_src.md
Name: xillybus_rd_stream_src

Overview:
- User-side source for a Xillybus FPGA-to-host read stream; it is the user-logic end of a user_r_* channel (rden/data/empty/eof/open).
- Accepts samples from acquisition logic (e.g. raw-signal or test-result producers) through a valid/ready handshake and buffers them in an internal FIFO.
- Serves the FIFO to the Xillybus core on rden and terminates each frame with eof after a programmed word count.

Parameters:
- DATA_W, 16, width of sample and stream data.
- DEPTH_LOG2, 9, log2 of FIFO depth in words (512).
- LEN_W, 16, width of the frame length input.

Ports:
- bus_clk  in  1  single clock, the Xillybus bus clock.
- bus_rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a frame.
- frame_len  in  LEN_W  words in the frame; sampled on an accepted start.
- smp_valid  in  1  producer word valid.
- smp_data  in  DATA_W  producer word.
- smp_ready  out  1  block can accept a producer word.
- user_r_rden  in  1  core read strobe.
- user_r_data  out  DATA_W  read data, registered.
- user_r_empty  out  1  FIFO empty.
- user_r_eof  out  1  end of frame.
- user_r_open  in  1  host has the device file open.
- busy  out  1  state is not IDLE.
- overflow  out  1  sticky: producer stalled during a frame.

Behaviour:
- Reset (asynchronous, bus_rst_n=0):
  - state=IDLE; FIFO pointers and count = 0; word counter = 0.
  - user_r_data=0, user_r_empty=1, user_r_eof=0, smp_ready=0, busy=0, overflow=0.
- FIFO:
  - DEPTH = 2^DEPTH_LOG2, with a (DEPTH_LOG2+1)-bit count.
  - Read latency is 1: user_r_data loads the head word on the clock edge after rden=1 with empty=0, and holds otherwise.
  - rden while empty is ignored: no pointer movement, data holds.
  - Simultaneous push and pop leaves the count unchanged; pointers wrap modulo DEPTH.
  - user_r_empty = (count==0), combinational from count.
- smp_ready = (state==STREAM) && (count!=DEPTH); combinational, so it drops as soon as the FIFO is full. A push happens when smp_valid && smp_ready.
- overflow:
  - Set when state==STREAM && smp_valid && count==DEPTH.
  - Cleared only by an accepted start or by reset.
- FSM states: IDLE, STREAM, DRAIN, EOF.
  - IDLE: start && user_r_open accepts the frame and latches frame_len. If frame_len==0, go to EOF; otherwise clear the word counter and go to STREAM. start while user_r_open=0 is ignored.
  - STREAM: each push increments the word counter. A push with counter==len-1 moves to DRAIN on that edge. The last word is written; smp_ready=0 from the next cycle.
  - DRAIN: when count==0 and no push or pop occurs this cycle, go to EOF.
  - EOF: user_r_eof=1 (registered; rises the cycle after entry). user_r_empty is 1 throughout. Stays here until user_r_open=0.
  - Any state: user_r_open=0 forces IDLE on the next edge. FIFO is flushed (pointers and count to 0), eof=0, overflow is unchanged. This takes priority over start in the same cycle.
- start while busy=1 is ignored; frame_len is not re-sampled.
- user_r_eof is never 1 while user_r_empty=0.
- Word counter is LEN_W bits; the maximum frame is 2^LEN_W-1 words with no wrap.

Test Plan:
- Basic frame: open=1, start with frame_len=4, producer offers 0x0011,0x0022,0x0033,0x0044 back-to-back, core reads whenever empty=0 -> user_r_data shows 0x0011..0x0044, each one cycle after its rden; eof=1 the cycle after the last word leaves (count 0); overflow=0.
- Full/backpressure: frame_len=600, no reads, smp_valid held high -> 512 words accepted, smp_ready=0 at count 512, overflow=1. Then start reads -> the remaining 88 words are accepted and all 600 are delivered in order; eof only after the 600th read.
- Zero length: start with frame_len=0 -> EOF state directly, empty=1, eof=1 one cycle later, smp_ready stays 0.
- Read on empty: rden pulsed with empty=1 mid-frame -> user_r_data unchanged, no count change. Simultaneous push and pop at count=3 -> count stays 3.
- Close mid-frame: frame_len=100, 30 words pushed, 10 read, then open=0 -> next cycle state IDLE, empty=1, eof=0, busy=0. start together with open=0 -> ignored.
- Async reset mid-DRAIN: bus_rst_n low between edges -> outputs immediately at reset values (empty=1, eof=0, data=0, overflow=0).
